// File: rtl/writeback_unit_if.sv
// Purpose : bundles the writeback-stage inputs and the register-file / CSR / redirect / trap outputs.
// Latency : n/a (wiring only).
// Backpressure: none; the writeback unit samples its inputs every cycle.
// Ports   : master = pipeline side (drives wb_* stage inputs, observes results);
//           slave  = writeback unit (consumes stage inputs, drives results).
interface writeback_unit_if #(
  parameter int XLEN = 64
);
  // writeback-stage instruction and candidate results
  logic            wb_v;
  logic [31:0]     wb_ir;
  logic [XLEN-1:0] wb_npc;
  logic [XLEN-1:0] wb_mem_result;
  logic [XLEN-1:0] wb_alu_result;
  logic [XLEN-1:0] wb_rfd;
  logic [XLEN-1:0] wb_csrfd;
  logic [4:0]      wb_drid;
  logic            wb_pc_mux;
  logic [6:0]      wb_exc;
  logic            wb_ecall;
  logic            timer;
  logic            external;
  logic            privilege;

  // register-file, CSR, redirect and trap results
  logic            rf_we;
  logic [XLEN-1:0] wb_rf_data;
  logic [4:0]      wb_drid_out;
  logic            csr_we;
  logic [XLEN-1:0] wb_csr_data;
  logic            pc_mux;
  logic [XLEN-1:0] wb_br_jmp_target;
  logic [31:0]     wb_ir_out;
  logic            cs;
  logic [XLEN-1:0] cause;
  logic            flushing;
  logic [XLEN-1:0] instret;

  modport master (
    output wb_v, wb_ir, wb_npc, wb_mem_result, wb_alu_result, wb_rfd, wb_csrfd,
           wb_drid, wb_pc_mux, wb_exc, wb_ecall, timer, external, privilege,
    input  rf_we, wb_rf_data, wb_drid_out, csr_we, wb_csr_data, pc_mux,
           wb_br_jmp_target, wb_ir_out, cs, cause, flushing, instret
  );

  modport slave (
    input  wb_v, wb_ir, wb_npc, wb_mem_result, wb_alu_result, wb_rfd, wb_csrfd,
           wb_drid, wb_pc_mux, wb_exc, wb_ecall, timer, external, privilege,
    output rf_we, wb_rf_data, wb_drid_out, csr_we, wb_csr_data, pc_mux,
           wb_br_jmp_target, wb_ir_out, cs, cause, flushing, instret
  );
endinterface

// File: rtl/writeback_unit.sv
// Purpose : writeback stage - result select, RF/CSR write, redirect, trap detection and post-trap flush.
// Latency : 1 cycle, every output is registered.
// Backpressure: none; after a trap, FLUSH_CYCLES cycles of input are discarded (flushing=1).
// Ports   : clk, reset_n (synchronous, active-low); bus = writeback_unit_if.slave.
// Config  : define WB_INSTRET_EN to build the retired-instruction counter; otherwise instret is 0.
module writeback_unit #(
  parameter int XLEN         = 64,  // 32 or 64
  parameter int FLUSH_CYCLES = 3    // 1..15
) (
  input logic           clk,
  input logic           reset_n,
  writeback_unit_if.slave bus
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // counter runs FLUSH_CYCLES-1 down to 0, one discarded cycle per value
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  // exception vector bit positions
  localparam int EXC_IAM = 0;
  localparam int EXC_IAF = 1;
  localparam int EXC_II  = 2;
  localparam int EXC_LAM = 3;
  localparam int EXC_LAF = 4;
  localparam int EXC_SAM = 5;
  localparam int EXC_SAF = 6;

  logic [0:0]      state;
  logic [3:0]      flush_cnt;

  logic            rf_we_q;
  logic [XLEN-1:0] rf_data_q;
  logic [4:0]      drid_q;
  logic            csr_we_q;
  logic [XLEN-1:0] csr_data_q;
  logic            pc_mux_q;
  logic [XLEN-1:0] target_q;
  logic [31:0]     ir_q;
  logic            cs_q;
  logic [XLEN-1:0] cause_q;

  // ---------------------------------------------------------------------------
  // Result select
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic            has_result;
  logic [XLEN-1:0] result;
  logic            csr_write;

  assign opcode = bus.wb_ir[6:0];

  always_comb begin
    has_result = 1'b1;
    result     = bus.wb_alu_result;
    case (opcode)
      OP_LOAD:                               result = bus.wb_mem_result;
      OP_IMM, OP_REG, OP_IMM32, OP_REG32,
      OP_LUI, OP_AUIPC:                      result = bus.wb_alu_result;
      OP_SYSTEM:                             result = bus.wb_rfd;
      OP_JAL, OP_JALR:                       result = bus.wb_npc;
      default:                               has_result = 1'b0;
    endcase
  end

  // funct3 == 000 covers ecall/ebreak/mret-style system ops that never touch a CSR
  assign csr_write = (opcode == OP_SYSTEM) && (bus.wb_ir[14:12] != 3'b000);

  // ---------------------------------------------------------------------------
  // Trap detection: synchronous exceptions first, interrupts only when none
  // ---------------------------------------------------------------------------
  logic            exc_hit;
  logic [3:0]      exc_code;
  logic            irq_hit;
  logic [3:0]      irq_code;
  logic            trap_hit;
  logic [XLEN-1:0] trap_cause;

  always_comb begin
    exc_hit  = 1'b1;
    exc_code = 4'd0;
    if (bus.wb_exc[EXC_IAF])      exc_code = 4'd1;
    else if (bus.wb_exc[EXC_II])  exc_code = 4'd2;
    else if (bus.wb_exc[EXC_IAM]) exc_code = 4'd0;
    else if (bus.wb_ecall)        exc_code = bus.privilege ? 4'd11 : 4'd8;
    else if (bus.wb_exc[EXC_SAM]) exc_code = 4'd6;
    else if (bus.wb_exc[EXC_LAM]) exc_code = 4'd4;
    else if (bus.wb_exc[EXC_SAF]) exc_code = 4'd7;
    else if (bus.wb_exc[EXC_LAF]) exc_code = 4'd5;
    else                          exc_hit  = 1'b0;
  end

  assign irq_hit  = bus.external || bus.timer;
  assign irq_code = bus.external ? 4'd11 : 4'd7;
  assign trap_hit = exc_hit || irq_hit;

  always_comb begin
    trap_cause           = '0;
    trap_cause[3:0]      = exc_hit ? exc_code : irq_code;
    trap_cause[XLEN-1]   = !exc_hit;
  end

  // ---------------------------------------------------------------------------
  // Accept / retire
  // ---------------------------------------------------------------------------
  logic accept;
  logic retire;
  logic take_trap;

  assign accept    = bus.wb_v && (state == ST_RUN);
  assign take_trap = accept && trap_hit;
  assign retire    = accept && !trap_hit;

  // ---------------------------------------------------------------------------
  // FSM and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      flush_cnt  <= 4'd0;
      rf_we_q    <= 1'b0;
      rf_data_q  <= '0;
      drid_q     <= 5'd0;
      csr_we_q   <= 1'b0;
      csr_data_q <= '0;
      pc_mux_q   <= 1'b0;
      target_q   <= '0;
      ir_q       <= 32'd0;
      cs_q       <= 1'b0;
      cause_q    <= '0;
    end else begin
      // strobes default low; data registers hold unless a retire/trap updates them
      rf_we_q  <= 1'b0;
      csr_we_q <= 1'b0;
      pc_mux_q <= 1'b0;
      cs_q     <= 1'b0;

      if (state == ST_FLUSH) begin
        if (flush_cnt == 4'd0) begin
          state <= ST_RUN;
        end else begin
          flush_cnt <= flush_cnt - 4'd1;
        end
      end else if (take_trap) begin
        cs_q      <= 1'b1;
        cause_q   <= trap_cause;
        state     <= ST_FLUSH;
        flush_cnt <= FLUSH_LAST;
      end else if (retire) begin
        rf_we_q  <= has_result && (bus.wb_drid != 5'd0);
        drid_q   <= bus.wb_drid;
        ir_q     <= bus.wb_ir;
        pc_mux_q <= bus.wb_pc_mux;
        target_q <= bus.wb_alu_result;
        // keep the last real result visible for instructions that produce none
        if (has_result) begin
          rf_data_q <= result;
        end
        if (csr_write) begin
          csr_we_q   <= 1'b1;
          csr_data_q <= bus.wb_csrfd;
        end
      end
    end
  end

  assign bus.rf_we            = rf_we_q;
  assign bus.wb_rf_data       = rf_data_q;
  assign bus.wb_drid_out      = drid_q;
  assign bus.csr_we           = csr_we_q;
  assign bus.wb_csr_data      = csr_data_q;
  assign bus.pc_mux           = pc_mux_q;
  assign bus.wb_br_jmp_target = target_q;
  assign bus.wb_ir_out        = ir_q;
  assign bus.cs               = cs_q;
  assign bus.cause            = cause_q;
  assign bus.flushing         = (state == ST_FLUSH);

  // ---------------------------------------------------------------------------
  // Retired-instruction counter
  // ---------------------------------------------------------------------------
`ifdef WB_INSTRET_EN
  logic [XLEN-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + XLEN'(1);
    end
  end

  assign bus.instret = instret_q;
`else
  assign bus.instret = '0;
`endif

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter XLEN, default 64, datapath and CAUSE width; legal values 32 and 64.
REQ-002 Parameter FLUSH_CYCLES, default 3, cycles of instruction discard after a trap; range 1..15.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RESET_N  in  1  synchronous, active-low reset.
REQ-005 WB_V  in  1  writeback-stage instruction valid.
REQ-006 WB_IR  in  32  instruction word.
REQ-007 WB_NPC, WB_MEM_RESULT, WB_ALU_RESULT, WB_RFD, WB_CSRFD  in  XLEN each  candidate results (PC+4, load data, ALU result, CSR old value, CSR new value).
REQ-008 WB_DRID  in  5  destination register index.
REQ-009 WB_PC_MUX  in  1  branch/jump taken.
REQ-010 WB_EXC  in  7  {SAF,SAM,LAF,LAM,II,IAF,IAM}, bit 0 = IAM.
REQ-011 WB_ECALL, TIMER, EXTERNAL, PRIVILEGE  in  1 each  ecall, interrupt requests (level), current mode (1 = M, 0 = U).
REQ-012 RF_WE  out  1; WB_RF_DATA  out  XLEN; WB_DRID_OUT  out  5: register-file write port.
REQ-013 CSR_WE  out  1; WB_CSR_DATA  out  XLEN: CSR write port.
REQ-014 PC_MUX  out  1; WB_BR_JMP_TARGET  out  XLEN: redirect request and target.
REQ-015 WB_IR_OUT  out  32  retiring instruction.
REQ-016 CS  out  1  context-switch pulse; CAUSE  out  XLEN  trap cause.
REQ-017 FLUSHING  out  1  discard window active; INSTRET  out  XLEN  retired count.

Function
REQ-018 All outputs SHALL be registered: one-cycle latency from inputs to outputs.
REQ-019 An instruction is accepted when WB_V=1 and the FSM is in RUN; an accepted instruction with no trap retires.
REQ-020 Result select by WB_IR[6:0]: 0000011 -> MEM_RESULT; 0010011, 0110011, 0011011, 0111011, 0110111, 0010111 -> ALU_RESULT; 1110011 -> RFD; 1101111, 1100111 -> NPC.
REQ-021 RF_WE SHALL be 1 for one cycle per retiring instruction of a REQ-020 opcode with WB_DRID!=0; otherwise 0.
REQ-022 CSR_WE SHALL be 1 for a retiring 1110011 with WB_IR[14:12]!=000; WB_CSR_DATA=WB_CSRFD.
REQ-023 PC_MUX=WB_PC_MUX and WB_BR_JMP_TARGET=WB_ALU_RESULT for a retiring instruction; PC_MUX=0 otherwise.
REQ-024 Non-accepted cycles: all write enables, PC_MUX, CS = 0; data outputs hold.
REQ-025 Exception priority: IAF(1) > II(2) > IAM(0) > ECALL(8 if PRIVILEGE=0, 11 if 1) > SAM(6) > LAM(4) > SAF(7) > LAF(5).
REQ-026 When no exception is present, an accepted instruction is preempted by EXTERNAL (CAUSE=MSB set, code 11), else TIMER (MSB set, code 7).
REQ-027 On a trap: CS=1 for exactly one cycle, CAUSE loaded (MSB = interrupt flag, other upper bits 0), RF_WE, CSR_WE, PC_MUX = 0, no retire; CAUSE holds until the next trap.
REQ-028 FSM states RUN and FLUSH; RUN -> FLUSH on trap; FLUSH counts FLUSH_CYCLES cycles then -> RUN; FLUSHING=1 in FLUSH.
REQ-029 In FLUSH, WB_V, WB_EXC, ECALL, TIMER, EXTERNAL are ignored; first post-flush instruction is accepted normally on the cycle FLUSHING returns to 0.

Reset
REQ-030 RESET_N=0 at a rising edge SHALL clear all outputs to 0, set FSM to RUN, clear the flush counter and INSTRET, including mid-FLUSH.

Configuration
REQ-031 Macro WB_INSTRET_EN defined: INSTRET increments by 1 per retire, wrapping from all-ones to 0.
REQ-032 Macro WB_INSTRET_EN undefined: no counter logic; INSTRET tied to 0.

Verification
REQ-033 WB_V=1, IR=0x00A00093 (addi x1), ALU=0x5 -> next cycle RF_WE=1, DRID_OUT=1, RF_DATA=0x5, INSTRET=1.
REQ-034 WB_V=1, IR=jal x0, PC_MUX=1, ALU=0x8000_0000 -> RF_WE=0, PC_MUX=1, target=0x8000_0000.
REQ-035 WB_V=1, WB_EXC=0b0000110 (IAF+II) -> CS pulse, CAUSE=1, RF_WE=0; WB_V=1 next 3 cycles -> no writes, FLUSHING=1 for 3 cycles.
REQ-036 WB_V=1, ECALL=1, PRIVILEGE=1, TIMER=1 -> CAUSE=11 (MSB clear); with no ECALL -> CAUSE=(1<<(XLEN-1))|7.
REQ-037 Trap then RESET_N=0 for one cycle during FLUSH -> FLUSHING=0, CAUSE=0, INSTRET=0; next addi retires normally.
